// File: rtl/stopwatch_core.sv
// stopwatch_core: button conditioning, start/stop/lap/clear control and a
// four-digit BCD 10 ms counter (00.00 .. 99.99 s) feeding the 7-seg driver.
// Digits show either the live count or a frozen lap value.
module stopwatch_core #(
  parameter int TICK_DIV        = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lap_btn,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  // Counter widths; a width of at least one bit keeps degenerate settings legal.
  localparam int P_W  = (TICK_DIV > 1)        ? $clog2(TICK_DIV)        : 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [P_W-1:0]  TICK_MAX = P_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);

  // Control states. The two *_LAP states show the frozen lap register.
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] RUN_LAP  = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] STOP_LAP = 3'd4;

  // Button index 0 is start/stop, index 1 is lap/clear.
  logic [1:0]      btn_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      db_lvl_r;
  logic [1:0]      press_r;
  logic [DB_W-1:0] db_cnt_r [2];

  logic [2:0]      state_r;
  logic [2:0]      state_nxt_s;
  logic [P_W-1:0]  presc_r;
  logic [P_W-1:0]  presc_nxt_s;
  logic [15:0]     count_r;
  logic [15:0]     count_nxt_s;
  logic [15:0]     lap_r;
  logic [15:0]     lap_nxt_s;
  logic [15:0]     disp_r;
  logic [15:0]     disp_nxt_s;
  logic [16:0]     inc_s;
  logic            running_r;
  logic            lap_active_r;
  logic            wrap_r;
  logic            running_nxt_s;
  logic            lap_active_nxt_s;
  logic            wrap_nxt_s;
  logic            start_s;
  logic            lap_s;
  logic            run_cur_s;
  logic            tick_s;
  logic            capture_s;
  logic            clear_s;

  // Adds one to a four-digit BCD value. Bit 16 is the carry out of the
  // top digit. Any digit at or above 9 with a carry in rolls to 0, so an
  // out-of-range digit can never propagate.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [16:0] r;
    logic        c;
    r = 17'd0;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[d*4 +: 4] = v[d*4 +: 4];
        c           = 1'b0;
      end
    end
    r[16] = c;
    return r;
  endfunction

  assign btn_s = {lap_btn, start_btn};

  // Synchronise, debounce and one-pulse both buttons; the press pulse is
  // raised on the same edge that the debounced level rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      db_lvl_r <= 2'b00;
      press_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_lvl_r[i]) begin
          db_cnt_r[i] <= '0;
          press_r[i]  <= 1'b0;
        end else if (db_cnt_r[i] == DB_MAX) begin
          db_cnt_r[i] <= '0;
          db_lvl_r[i] <= sync2_r[i];
          press_r[i]  <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          press_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Start wins when both presses land in the same cycle.
  assign start_s = press_r[0];
  assign lap_s   = press_r[1] & ~press_r[0];

  // Next-state decode plus lap capture and clear strobes.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (start_s) begin
          state_nxt_s = STOP;
        end else if (lap_s) begin
          state_nxt_s = RUN_LAP;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RUN_LAP: begin
        if (start_s) begin
          state_nxt_s = STOP_LAP;
        end else if (lap_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = RUN_LAP;
        end
      end
      STOP: begin
        if (start_s) begin
          state_nxt_s = RUN;
        end else if (lap_s) begin
          state_nxt_s = IDLE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = STOP;
        end
      end
      STOP_LAP: begin
        if (start_s) begin
          state_nxt_s = RUN_LAP;
        end else if (lap_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = STOP_LAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign run_cur_s = (state_r == RUN) || (state_r == RUN_LAP);
  assign tick_s    = run_cur_s && (presc_r == TICK_MAX);
  assign inc_s     = bcd_inc(count_r);

  // Prescaler, BCD count, lap register and display next values.
  always_comb begin
    presc_nxt_s      = presc_r;
    count_nxt_s      = count_r;
    lap_nxt_s        = lap_r;
    wrap_nxt_s       = 1'b0;
    if (clear_s) begin
      presc_nxt_s = '0;
      count_nxt_s = 16'h0000;
    end else if (tick_s) begin
      presc_nxt_s = '0;
      count_nxt_s = inc_s[15:0];
      wrap_nxt_s  = inc_s[16];
    end else if (run_cur_s) begin
      presc_nxt_s = presc_r + P_W'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
    // Capture uses the pre-increment count when a tick lands on the same edge.
    if (capture_s) begin
      lap_nxt_s = count_r;
    end else begin
      lap_nxt_s = lap_r;
    end
    running_nxt_s    = (state_nxt_s == RUN) || (state_nxt_s == RUN_LAP);
    lap_active_nxt_s = (state_nxt_s == RUN_LAP) || (state_nxt_s == STOP_LAP);
    if (lap_active_nxt_s) begin
      disp_nxt_s = lap_nxt_s;
    end else begin
      disp_nxt_s = count_nxt_s;
    end
  end

  // State, counters and the registered outputs all advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      presc_r      <= '0;
      count_r      <= 16'h0000;
      lap_r        <= 16'h0000;
      disp_r       <= 16'h0000;
      running_r    <= 1'b0;
      lap_active_r <= 1'b0;
      wrap_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      presc_r      <= presc_nxt_s;
      count_r      <= count_nxt_s;
      lap_r        <= lap_nxt_s;
      disp_r       <= disp_nxt_s;
      running_r    <= running_nxt_s;
      lap_active_r <= lap_active_nxt_s;
      wrap_r       <= wrap_nxt_s;
    end
  end

  assign s0         = disp_r[3:0];
  assign s1         = disp_r[7:4];
  assign s2         = disp_r[11:8];
  assign s3         = disp_r[15:12];
  assign running    = running_r;
  assign lap_active = lap_active_r;
  assign wrap       = wrap_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A button driven high just after edge X produces its state change at edge X+6;
// after entering RUN at edge R the count equals n after edge R+4n.
module tb_stopwatch_core;

  logic        clk;
  logic        reset;
  logic        start_btn;
  logic        lap_btn;
  logic [3:0]  s0;
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [3:0]  s3;
  logic        running;
  logic        lap_active;
  logic        wrap;
  logic [15:0] disp;

  int checks   = 0;
  int failures = 0;

  stopwatch_core #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .lap_btn    (lap_btn),
    .s0         (s0),
    .s1         (s1),
    .s2         (s2),
    .s3         (s3),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  assign disp = {s3, s2, s1, s0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    #12;
    check("rst_disp", disp, 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_lap_active", {15'd0, lap_active}, 16'd0);
    check("rst_wrap", {15'd0, wrap}, 16'd0);
    reset = 1'b1;
    step(1);

    // Short glitch on start: no press, stays IDLE.
    start_btn = 1'b1;
    step(2);
    start_btn = 1'b0;
    step(10);
    check("glitch_running", {15'd0, running}, 16'd0);
    check("glitch_disp", disp, 16'h0000);

    // Held press: RUN appears exactly six edges after the input rises.
    start_btn = 1'b1;
    step(5);
    check("latency_not_yet", {15'd0, running}, 16'd0);
    step(1);
    start_btn = 1'b0;
    check("start_running", {15'd0, running}, 16'd1);
    check("start_lap_active", {15'd0, lap_active}, 16'd0);

    // 40 cycles of RUN = 10 ticks = 00.10.
    step(40);
    check("run40_disp", disp, 16'h0010);

    // Asynchronous reset mid-count clears outputs without a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_disp", disp, 16'h0000);
    check("async_rst_running", {15'd0, running}, 16'd0);
    check("async_rst_lap_active", {15'd0, lap_active}, 16'd0);
    #2;
    reset = 1'b1;
    step(6);
    check("post_rst_idle", {15'd0, running}, 16'd0);
    check("post_rst_disp", disp, 16'h0000);

    // Full run to 99.99 and roll over.
    start_btn = 1'b1;
    step(6);
    start_btn = 1'b0;
    step(39999);
    check("pre_wrap_disp", disp, 16'h9999);
    check("pre_wrap_flag", {15'd0, wrap}, 16'd0);
    step(1);
    check("wrap_disp", disp, 16'h0000);
    check("wrap_flag", {15'd0, wrap}, 16'd1);
    step(1);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    check("post_wrap_disp", disp, 16'h0000);

    // Lap capture at 00.12 (captured on edge R+40050; count reached 12 at R+40048).
    step(43);
    lap_btn = 1'b1;
    step(6);
    lap_btn = 1'b0;
    check("lap_active_on", {15'd0, lap_active}, 16'd1);
    check("lap_running", {15'd0, running}, 16'd1);
    check("lap_freeze", disp, 16'h0012);
    step(8);
    check("lap_still_frozen", disp, 16'h0012);
    lap_btn = 1'b1;
    step(6);
    lap_btn = 1'b0;
    check("lap_release_live", disp, 16'h0016);
    check("lap_active_off", {15'd0, lap_active}, 16'd0);

    // Stop holds the count; lap from STOP clears to IDLE.
    start_btn = 1'b1;
    step(6);
    start_btn = 1'b0;
    check("stop_running", {15'd0, running}, 16'd0);
    check("stop_disp", disp, 16'h0017);
    step(12);
    check("stop_hold", disp, 16'h0017);
    lap_btn = 1'b1;
    step(6);
    lap_btn = 1'b0;
    check("clear_disp", disp, 16'h0000);
    check("clear_running", {15'd0, running}, 16'd0);
    check("clear_lap_active", {15'd0, lap_active}, 16'd0);
    step(3);
    lap_btn = 1'b1;
    step(6);
    lap_btn = 1'b0;
    step(4);
    check("idle_lap_ignored_running", {15'd0, running}, 16'd0);
    check("idle_lap_ignored_lap", {15'd0, lap_active}, 16'd0);
    check("idle_lap_ignored_disp", disp, 16'h0000);

    // Simultaneous start and lap from RUN: start wins, goes to STOP.
    start_btn = 1'b1;
    step(6);
    start_btn = 1'b0;
    check("restart_running", {15'd0, running}, 16'd1);
    step(8);
    start_btn = 1'b1;
    lap_btn   = 1'b1;
    step(6);
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    check("both_running", {15'd0, running}, 16'd0);
    check("both_lap_active", {15'd0, lap_active}, 16'd0);
    check("both_disp", disp, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
